// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, req/ack imem fetch, valid/ready hand-off to decode; one beat per 2 cycles min, outputs registered.
// Redirects squash wrong-path fetches; optional perf counters under IFU_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_pc_plus4
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {REQ, HOLD, DROP} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pc, pc_n;
  logic             req_n, valid_n;
  logic [WIDTH-1:0] addr_n, instr_n, opc_n, opc4_n;
  logic [WIDTH-1:0] target, pc_inc;

  assign target = redirect_pc & {{(WIDTH-2){1'b1}}, 2'b00};
  assign pc_inc = pc + WIDTH'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= REQ;
      pc           <= RESET_PC;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_pc       <= '0;
      out_pc_plus4 <= '0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      imem_req     <= req_n;
      imem_addr    <= addr_n;
      out_valid    <= valid_n;
      out_instr    <= instr_n;
      out_pc       <= opc_n;
      out_pc_plus4 <= opc4_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = imem_req;
    addr_n  = imem_addr;
    valid_n = out_valid;
    instr_n = out_instr;
    opc_n   = out_pc;
    opc4_n  = out_pc_plus4;
    case (state)
      REQ: begin
        if (redirect_valid) begin
          pc_n = target;
          // An unacked request is still in flight and must be drained in DROP.
          if (!imem_req || imem_ack) begin
            req_n  = 1'b1;
            addr_n = target;
          end else begin
            state_n = DROP;
          end
        end else if (!imem_req) begin
          req_n  = 1'b1;
          addr_n = pc;
        end else if (imem_ack) begin
          instr_n = imem_rdata;
          opc_n   = pc;
          opc4_n  = pc_inc;
          valid_n = 1'b1;
          pc_n    = pc_inc;
          req_n   = 1'b0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          valid_n = 1'b0;
          pc_n    = target;
          req_n   = 1'b1;
          addr_n  = target;
          state_n = REQ;
        end else if (out_ready) begin
          valid_n = 1'b0;
          req_n   = 1'b1;
          addr_n  = pc;
          state_n = REQ;
        end
      end
      DROP: begin
        if (redirect_valid) pc_n = target;
        if (imem_ack) begin
          addr_n  = redirect_valid ? target : pc;
          state_n = REQ;
        end
      end
      default: state_n = REQ;
    endcase
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (out_valid && out_ready) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if ((imem_req && !imem_ack) || (out_valid && !out_ready))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  // Counters absent in this build.
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed fetch, stall, redirect, reset and wrap scenarios.
module tb_instr_fetch_unit;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] plus4;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        imem_req, imem_ack, redirect_valid, out_valid, out_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc, out_pc_plus4;
  logic        req2, ack2, valid2;
  logic [31:0] addr2, rdata2, instr2, pc2, pc4_2;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_fetch2, perf_stall2;
`endif

  int    errors = 0, checks = 0, cyc = 0, mem_wait = 0, mem_cnt = 0;
  int    model_fetch = 0, model_stall = 0;
  bit    misalign = 0, unstable = 0, prev_pend = 0;
  logic [31:0] prev_addr = '0;
  beat_t exp_q[$], exp2_q[$];
  int    acc_time[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  instr_fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2),
    .imem_rdata(rdata2), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(valid2), .out_ready(1'b1), .out_instr(instr2), .out_pc(pc2),
    .out_pc_plus4(pc4_2)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch2), .perf_stall_cnt(perf_stall2)
`endif
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic beat_t mk(input logic [31:0] p);
    beat_t b;
    b.instr = word(p);
    b.pc    = p;
    b.plus4 = p + 32'd4;
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Second instance sees a zero-wait memory.
  assign ack2   = req2;
  assign rdata2 = word(addr2);

  // Memory for the main DUT: acks after mem_wait stall cycles.
  always @(posedge clk) begin
    #1;
    if (imem_req && mem_cnt >= mem_wait) begin
      imem_ack   = 1'b1;
      imem_rdata = word(imem_addr);
      mem_cnt    = 0;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      mem_cnt    = imem_req ? mem_cnt + 1 : 0;
    end
  end

  // Monitor: pops the scoreboard on each accepted beat and tracks protocol invariants.
  always @(negedge clk) begin
    beat_t e;
    #1;
    if (rst) begin
      model_fetch = 0;
      model_stall = 0;
      prev_pend   = 0;
    end else begin
      if (imem_addr[1:0] != 2'b00) misalign = 1;
      if (prev_pend && (!imem_req || imem_addr != prev_addr)) unstable = 1;
      prev_pend = imem_req && !imem_ack;
      prev_addr = imem_addr;
      if ((imem_req && !imem_ack) || (out_valid && !out_ready)) model_stall++;
      if (out_valid && out_ready) begin
        model_fetch++;
        acc_time.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: actual pc=%h required none", out_pc);
        end else begin
          e = exp_q.pop_front();
          check("beat_pc", out_pc, e.pc);
          check("beat_instr", out_instr, e.instr);
          check("beat_pc_plus4", out_pc_plus4, e.plus4);
        end
      end
    end
    if (!rst2 && valid2 && exp2_q.size() > 0) begin
      e = exp2_q.pop_front();
      check("wrap_pc", pc2, e.pc);
      check("wrap_instr", instr2, e.instr);
      check("wrap_pc_plus4", pc4_2, e.plus4);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_hold(input logic [31:0] p);
    int n = 0;
    while (!(out_valid && out_pc == p) && n < 60) begin
      tick();
      n++;
    end
    check($sformatf("reach_hold_%0h", p), 32'(out_valid && out_pc == p), 32'd1);
  endtask

  task automatic wait_req(input logic [31:0] a);
    int n = 0;
    while (!(imem_req && imem_addr == a) && n < 60) begin
      tick();
      n++;
    end
    check($sformatf("reach_req_%0h", a), 32'(imem_req && imem_addr == a), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; rst2 = 1'b1; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    exp2_q.push_back(mk(32'hFFFF_FFFC));
    exp2_q.push_back(mk(32'h0000_0000));
    exp2_q.push_back(mk(32'h0000_0004));
    tick(); tick();
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_pc_plus4", out_pc_plus4, 32'h0);
    check("rst2_imem_addr", addr2, 32'hFFFF_FFFC);
`ifdef IFU_PERF_CNT_EN
    check("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    check("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif

    // Zero-wait sequential fetch, then a 5-cycle downstream stall on pc 8.
    rst = 1'b0; rst2 = 1'b0; out_ready = 1'b1;
    exp_q.push_back(mk(32'h0));
    exp_q.push_back(mk(32'h4));
    wait_hold(32'h8);
    out_ready = 1'b0;
    check("accepts_before_8", acc_time.size(), 32'd2);
    if (acc_time.size() >= 2) check("beat_spacing", acc_time[1] - acc_time[0], 32'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_pc", out_pc, 32'h8);
      check("stall_instr", out_instr, word(32'h8));
      check("stall_pc_plus4", out_pc_plus4, 32'hC);
      check("stall_imem_req", 32'(imem_req), 32'd0);
    end
    exp_q.push_back(mk(32'h8));
    exp_q.push_back(mk(32'hC));
    out_ready = 1'b1;

    // Reset while a slow request is outstanding.
    wait_hold(32'hC);
    mem_wait = 3;
    wait_req(32'h10);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_imem_req", 32'(imem_req), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_imem_addr", imem_addr, 32'h0);
`ifdef IFU_PERF_CNT_EN
    check("midrst_perf_fetch", perf_fetch_cnt, 32'd0);
    check("midrst_perf_stall", perf_stall_cnt, 32'd0);
`endif
    rst = 1'b0; mem_wait = 0;
    exp_q.push_back(mk(32'h0));
    wait_hold(32'h0);

    // Redirect while addr 4 is stalled: its word is dropped, fetch resumes at 0x100.
    mem_wait = 3;
    wait_req(32'h4);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0101;
    exp_q.push_back(mk(32'h100));
    exp_q.push_back(mk(32'h104));
    tick();
    redirect_valid = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 3; i++) begin
      check("drop_imem_req", 32'(imem_req), 32'd1);
      check("drop_imem_addr", imem_addr, 32'h4);
      tick();
    end
    check("after_drop_req", 32'(imem_req), 32'd1);
    check("after_drop_addr", imem_addr, 32'h100);
    mem_wait = 0;

    // Redirect in HOLD with out_ready=0: held 0x108 is squashed.
    wait_hold(32'h108);
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    exp_q.push_back(mk(32'h200));
    tick();
    redirect_valid = 1'b0;
    check("squash_out_valid", 32'(out_valid), 32'd0);
    check("squash_imem_addr", imem_addr, 32'h200);
    out_ready = 1'b1;

    // Redirect in HOLD with out_ready=1: 0x200 still counts as accepted.
    wait_hold(32'h200);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    exp_q.push_back(mk(32'h300));
    tick();
    redirect_valid = 1'b0;
    check("hold_rdy_redirect_addr", imem_addr, 32'h300);
    check("hold_rdy_redirect_valid", 32'(out_valid), 32'd0);

    // Redirect in REQ coinciding with a zero-wait ack.
    wait_req(32'h304);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0403;
    exp_q.push_back(mk(32'h400));
    tick();
    redirect_valid = 1'b0;
    check("req_ack_redirect_req", 32'(imem_req), 32'd1);
    check("req_ack_redirect_addr", imem_addr, 32'h400);

    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("wrap_drained", exp2_q.size(), 32'd0);
    check("addr_aligned", 32'(misalign), 32'd0);
    check("req_addr_stable", 32'(unstable), 32'd0);
`ifdef IFU_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, 32'(model_fetch));
    check("perf_stall", perf_stall_cnt, 32'(model_stall));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
